// File: rtl/sound_arbiter_if.sv
// Bus between the game-event request sources and the sound arbiter.
// Handshake: req bits are one-cycle pulses with no ready; a request is taken in the cycle it is high.
// Everything the arbiter drives is registered or decoded from registered state.
interface sound_arbiter_if;
  logic [3:0] req;
  logic       mute;
  logic [3:0] grant;
  logic [1:0] tone_id;
  logic       playing;
  logic       done;
  logic [3:0] pending;
  logic [1:0] dbg_state;

  modport master (
    output req, mute,
    input  grant, tone_id, playing, done, pending, dbg_state
  );

  modport slave (
    input  req, mute,
    output grant, tone_id, playing, done, pending, dbg_state
  );
endinterface

// File: rtl/sound_arbiter.sv
// Fixed-priority owner of the single tone path. Latches request pulses, times each sound,
// and inserts a silent gap after every sound that runs to completion.
module sound_arbiter #(
  parameter int DUR_W = 28,
  parameter int DUR0  = 25_000_000,
  parameter int DUR1  = 50_000_000,
  parameter int DUR2  = 50_000_000,
  parameter int DUR3  = 150_000_000,
  parameter int GAP   = 1_000_000
) (
  input  logic            clk,
  input  logic            reset,
  sound_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [DUR_W-1:0] LOAD0 = DUR_W'(DUR0 - 1);
  localparam logic [DUR_W-1:0] LOAD1 = DUR_W'(DUR1 - 1);
  localparam logic [DUR_W-1:0] LOAD2 = DUR_W'(DUR2 - 1);
  localparam logic [DUR_W-1:0] LOAD3 = DUR_W'(DUR3 - 1);
  localparam logic [DUR_W-1:0] LOADG = DUR_W'(GAP - 1);

  state_t           state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       pending_q, pending_d;
  logic             done_q, done_d;

  logic [3:0] cand, cand_ex, win_mask, win_ex_mask;
  logic [1:0] win, win_ex;
  logic       higher;

  function automatic logic [1:0] pick(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [DUR_W-1:0] dur_load(input logic [1:0] id);
    case (id)
      2'd0:    return LOAD0;
      2'd1:    return LOAD1;
      2'd2:    return LOAD2;
      default: return LOAD3;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      owner_q   <= 2'd0;
      pending_q <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // A re-request by the current owner is merged away, so it never preempts or queues.
  always_comb begin
    cand        = pending_q | bus.req;
    cand_ex     = cand & ~(4'b0001 << owner_q);
    higher      = |(cand_ex & (4'b1110 << owner_q));
    win         = pick(cand);
    win_mask    = 4'b0001 << win;
    win_ex      = pick(cand_ex);
    win_ex_mask = 4'b0001 << win_ex;

    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    pending_d = pending_q;
    done_d    = 1'b0;

    if (bus.mute) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      owner_d   = 2'd0;
      pending_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cand != 4'd0) begin
            state_d   = S_PLAY;
            owner_d   = win;
            cnt_d     = dur_load(win);
            pending_d = cand & ~win_mask;
          end
        end
        S_PLAY: begin
          if (higher) begin
            owner_d   = win_ex;
            cnt_d     = dur_load(win_ex);
            pending_d = cand_ex & ~win_ex_mask;
          end else begin
            pending_d = cand_ex;
            if (cnt_q == '0) begin
              state_d = S_GAP;
              cnt_d   = LOADG;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        S_GAP: begin
          pending_d = cand;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (cand != 4'd0) begin
            state_d   = S_PLAY;
            owner_d   = win;
            cnt_d     = dur_load(win);
            pending_d = cand & ~win_mask;
          end else begin
            state_d = S_IDLE;
            owner_d = 2'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.playing   = (state_q == S_PLAY);
    bus.grant     = 4'd0;
    bus.tone_id   = 2'd0;
    bus.done      = done_q;
    bus.pending   = pending_q;
    bus.dbg_state = state_q;
    if (state_q == S_PLAY) begin
      bus.grant   = 4'b0001 << owner_q;
      bus.tone_id = owner_q;
    end
  end

endmodule
